// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - round-robin fetch/LSU arbiter onto one memory channel with in-order response routing
package riscv_mem_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [3:0]  id;
    } memory_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  id;
        logic        err;
        logic        last;
    } memory_rsp_t;
endpackage

module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 if_req_valid_i,
    output logic                                 if_req_ready_o,
    input  memory_req_t                          if_req_i,
    output logic                                 if_rsp_valid_o,
    output memory_rsp_t                          if_rsp_o,
    input  logic                                 lsu_req_valid_i,
    output logic                                 lsu_req_ready_o,
    input  memory_req_t                          lsu_req_i,
    output logic                                 lsu_rsp_valid_o,
    output memory_rsp_t                          lsu_rsp_o,
    output logic                                 mem_req_valid_o,
    input  logic                                 mem_req_ready_i,
    output memory_req_t                          mem_req_o,
    input  logic                                 mem_rsp_valid_i,
    input  memory_rsp_t                          mem_rsp_i,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
    output logic                                 spurious_rsp_o
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic                       last_grant;
    logic                       lock;
    logic                       lock_owner;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       spurious;

    logic can_issue;
    logic winner;
    logic handshake;
    logic fifo_empty;
    logic head_owner;
    logic rsp_routed;
    logic push;
    logic pop;

    // Registered count only: a same-cycle pop never frees a slot for a new grant.
    assign can_issue = count < CNT_W'(MAX_OUTSTANDING);

    always_comb begin
        winner = 1'b0;
        if (lock)
            winner = lock_owner;
        else if (if_req_valid_i && lsu_req_valid_i)
            winner = ~last_grant;
        else if (lsu_req_valid_i)
            winner = 1'b1;
    end

    assign mem_req_valid_o = lock | (can_issue & (if_req_valid_i | lsu_req_valid_i));
    assign mem_req_o       = winner ? lsu_req_i : if_req_i;
    assign handshake       = mem_req_valid_o & mem_req_ready_i;
    assign if_req_ready_o  = handshake & ~winner;
    assign lsu_req_ready_o = handshake & winner;

    assign fifo_empty      = (count == '0);
    assign head_owner      = owner_q[rd_ptr];
    assign rsp_routed      = mem_rsp_valid_i & ~fifo_empty;
    assign if_rsp_valid_o  = rsp_routed & ~head_owner;
    assign lsu_rsp_valid_o = rsp_routed & head_owner;
    assign if_rsp_o        = mem_rsp_i;
    assign lsu_rsp_o       = mem_rsp_i;

    assign push = handshake;
    assign pop  = rsp_routed & mem_rsp_i.last;

    assign outstanding_o  = count;
    assign spurious_rsp_o = spurious;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_grant <= 1'b0;
            lock       <= 1'b0;
            lock_owner <= 1'b0;
            owner_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            spurious   <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                last_grant      <= winner;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            if (handshake) begin
                lock <= 1'b0;
            end else if (mem_req_valid_o) begin
                lock       <= 1'b1;
                lock_owner <= winner;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (mem_rsp_valid_i && fifo_empty)
                spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;
    import riscv_mem_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    memory_req_t if_req, lsu_req, mem_req;
    memory_rsp_t if_rsp, lsu_rsp, mem_rsp;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [2:0]  outstanding;
    logic        spurious_rsp;

    int n_cmp = 0;
    int n_bad = 0;

    memory_req_t req_a, req_b, req_l, req_f;
    memory_rsp_t rsp_last, rsp_mid;

    riscv_mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .if_req_valid_i (if_req_valid),
        .if_req_ready_o (if_req_ready),
        .if_req_i       (if_req),
        .if_rsp_valid_o (if_rsp_valid),
        .if_rsp_o       (if_rsp),
        .lsu_req_valid_i(lsu_req_valid),
        .lsu_req_ready_o(lsu_req_ready),
        .lsu_req_i      (lsu_req),
        .lsu_rsp_valid_o(lsu_rsp_valid),
        .lsu_rsp_o      (lsu_rsp),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_o      (mem_req),
        .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_i      (mem_rsp),
        .outstanding_o  (outstanding),
        .spurious_rsp_o (spurious_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        if_req_valid  = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        req_a    = '{addr: 32'h0000_1000, wdata: 32'h0,         be: 4'hf, we: 1'b0, id: 4'h1};
        req_b    = '{addr: 32'h0000_2000, wdata: 32'hdead_beef, be: 4'h3, we: 1'b1, id: 4'h2};
        req_l    = '{addr: 32'h0000_3000, wdata: 32'h1234_5678, be: 4'hf, we: 1'b1, id: 4'h5};
        req_f    = '{addr: 32'h0000_4000, wdata: 32'h0,         be: 4'hf, we: 1'b0, id: 4'h6};
        rsp_last = '{rdata: 32'hcafe_f00d, id: 4'h1, err: 1'b0, last: 1'b1};
        rsp_mid  = '{rdata: 32'h0bad_0bad, id: 4'h1, err: 1'b0, last: 1'b0};
        if_req   = req_a;
        lsu_req  = req_b;
        mem_rsp  = rsp_last;

        // Reset state
        idle();
        rst_ni = 1'b0;
        tick();
        tick();
        check("rst_if_ready", if_req_ready, 0);
        check("rst_lsu_ready", lsu_req_ready, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_spurious", spurious_rsp, 0);
        check("rst_mem_req_fetch", mem_req, req_a);
        rst_ni = 1'b1;

        // Single fetch and its response
        if_req_valid = 1'b1; mem_req_ready = 1'b1;
        #1;
        check("t1_if_ready", if_req_ready, 1);
        check("t1_lsu_ready", lsu_req_ready, 0);
        check("t1_mem_req", mem_req, req_a);
        tick();
        idle();
        check("t1_outstanding1", outstanding, 1);
        mem_rsp = rsp_last; mem_rsp_valid = 1'b1;
        #1;
        check("t1_if_rsp_valid", if_rsp_valid, 1);
        check("t1_lsu_rsp_valid", lsu_rsp_valid, 0);
        check("t1_if_rsp", if_rsp, rsp_last);
        tick();
        idle();
        check("t1_outstanding0", outstanding, 0);

        // Both valid: LSU, fetch, LSU, fetch, then full
        do_reset();
        if_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_lsu_ready%0d", i), lsu_req_ready, (i % 2 == 0));
            check($sformatf("t2_if_ready%0d", i), if_req_ready, (i % 2 == 1));
            check($sformatf("t2_mem_req%0d", i), mem_req, (i % 2 == 0) ? req_b : req_a);
            tick();
        end
        #1;
        check("t2_outstanding4", outstanding, 4);
        check("t2_full_if_ready", if_req_ready, 0);
        check("t2_full_lsu_ready", lsu_req_ready, 0);
        check("t2_full_mem_valid", mem_req_valid, 0);

        // Full FIFO: pop and request in the same cycle
        mem_rsp = rsp_last; mem_rsp_valid = 1'b1;
        #1;
        check("t6_pop_lsu_rsp", lsu_rsp_valid, 1);
        check("t6_pop_if_rsp", if_rsp_valid, 0);
        check("t6_same_if_ready", if_req_ready, 0);
        check("t6_same_lsu_ready", lsu_req_ready, 0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check("t6_outstanding3", outstanding, 3);
        check("t6_next_lsu_ready", lsu_req_ready, 1);
        check("t6_next_if_ready", if_req_ready, 0);
        tick();
        idle();
        check("t6_outstanding4", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1;
            #1;
            check($sformatf("t6_drain_if%0d", i), if_rsp_valid, (i % 2 == 0));
            check($sformatf("t6_drain_lsu%0d", i), lsu_rsp_valid, (i % 2 == 1));
            tick();
        end
        idle();
        check("t6_drained", outstanding, 0);

        // Lock: stalled LSU holds the grant against fetch
        do_reset();
        lsu_req_valid = 1'b1; mem_req_ready = 1'b1;
        tick();
        idle();
        mem_rsp_valid = 1'b1;
        tick();
        idle();
        lsu_req = req_l; if_req = req_f;
        lsu_req_valid = 1'b1;
        #1;
        check("t3_c1_mem_valid", mem_req_valid, 1);
        check("t3_c1_mem_req", mem_req, req_l);
        check("t3_c1_lsu_ready", lsu_req_ready, 0);
        tick();
        if_req_valid = 1'b1;
        #1;
        check("t3_c2_mem_req", mem_req, req_l);
        check("t3_c2_if_ready", if_req_ready, 0);
        tick();
        #1;
        check("t3_c3_mem_req", mem_req, req_l);
        tick();
        mem_req_ready = 1'b1;
        #1;
        check("t3_c4_lsu_ready", lsu_req_ready, 1);
        check("t3_c4_if_ready", if_req_ready, 0);
        check("t3_c4_mem_req", mem_req, req_l);
        tick();
        lsu_req_valid = 1'b0;
        #1;
        check("t3_c5_if_ready", if_req_ready, 1);
        check("t3_c5_mem_req", mem_req, req_f);
        tick();
        idle();
        check("t3_outstanding2", outstanding, 2);
        mem_rsp_valid = 1'b1;
        #1;
        check("t3_rsp0_lsu", lsu_rsp_valid, 1);
        tick();
        #1;
        check("t3_rsp1_if", if_rsp_valid, 1);
        tick();
        idle();

        // Burst response for fetch, then single beat for LSU
        do_reset();
        if_req = req_a; lsu_req = req_b;
        if_req_valid = 1'b1; mem_req_ready = 1'b1;
        tick();
        if_req_valid = 1'b0; lsu_req_valid = 1'b1;
        tick();
        idle();
        check("t4_outstanding2", outstanding, 2);
        for (int i = 0; i < 4; i++) begin
            mem_rsp = (i == 3) ? rsp_last : rsp_mid;
            mem_rsp_valid = 1'b1;
            #1;
            check($sformatf("t4_beat%0d_if", i), if_rsp_valid, 1);
            check($sformatf("t4_beat%0d_lsu", i), lsu_rsp_valid, 0);
            tick();
            mem_rsp_valid = 1'b0;
            if (i < 3) check($sformatf("t4_beat%0d_held", i), outstanding, 2);
            tick();
        end
        check("t4_outstanding1", outstanding, 1);
        mem_rsp = rsp_last; mem_rsp_valid = 1'b1;
        #1;
        check("t4_lsu_beat_lsu", lsu_rsp_valid, 1);
        check("t4_lsu_beat_if", if_rsp_valid, 0);
        tick();
        idle();
        check("t4_outstanding0", outstanding, 0);

        // Spurious response with empty FIFO
        mem_rsp_valid = 1'b1;
        #1;
        check("t5_if_rsp", if_rsp_valid, 0);
        check("t5_lsu_rsp", lsu_rsp_valid, 0);
        check("t5_spurious_pre", spurious_rsp, 0);
        tick();
        idle();
        check("t5_spurious_set", spurious_rsp, 1);
        tick();
        tick();
        check("t5_spurious_sticky", spurious_rsp, 1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("t5_spurious_clr", spurious_rsp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
